// File: rtl/module_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the bit-counter width helper.
package module_serial_adder_pkg;

    // IDLE waits for a request, ADD runs one bit per clock, DONE presents the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0 .. w-1 (w >= 2).
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/module_serial_adder_full_adder.sv
// One-bit full adder cell used as the serial adder's only arithmetic element.
module module_full_adder (
    input  logic i_bit1,
    input  logic i_bit2,
    input  logic i_carry,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_bit1 ^ i_bit2 ^ i_carry;
    assign o_carry = (i_bit1 & i_bit2) | (i_bit1 & i_carry) | (i_bit2 & i_carry);

endmodule

// File: rtl/module_serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB first through a single
// full adder with the ripple carry held in a flip-flop. The result is
// registered and announced by a one-cycle o_valid pulse.
module module_serial_adder
    import module_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_operand1,
    input  logic [WIDTH-1:0] i_operand2,
    input  logic             i_carry,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_valid
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    // Upper WIDTH-1 bits of the partial sum; the lowest bit of a full-width
    // sum shift register is always shifted out before it is read, so it is
    // not stored.
    logic [WIDTH-2:0] r_s_sr;
    logic             r_c_q;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic             w_accept;
    logic             w_in_add;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_carry;
    logic [WIDTH-2:0] w_fa_sum_msb;

    assign o_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign o_valid  = (r_state == ST_DONE);
    assign o_sum    = r_sum;
    assign o_carry  = r_carry;

    assign w_accept = i_start && o_ready;
    assign w_in_add = (r_state == ST_ADD);
    assign w_last   = w_in_add && (r_cnt == CNT_LAST);

    // New sum bit positioned at the top of the partial-sum register.
    assign w_fa_sum_msb = (WIDTH - 1)'(w_fa_sum) << (WIDTH - 2);

    module_full_adder u_fa (
        .i_bit1  (r_a_sr[0]),
        .i_bit2  (r_b_sr[0]),
        .i_carry (r_c_q),
        .o_sum   (w_fa_sum),
        .o_carry (w_fa_carry)
    );

    // Next-state logic: DONE lasts one cycle and doubles as an accept slot.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_ADD;
            ST_ADD:  if (w_last)   w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = w_accept ? ST_ADD : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and bit counter; the counter stops at WIDTH-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= '0;
            end else if (w_in_add && !w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Operand shifters, ripple carry, partial sum and the held result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_c_q   <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_a_sr <= i_operand1;
            r_b_sr <= i_operand2;
            r_c_q  <= i_carry;
            r_s_sr <= '0;
        end else if (w_in_add) begin
            r_a_sr <= r_a_sr >> 1;
            r_b_sr <= r_b_sr >> 1;
            r_c_q  <= w_fa_carry;
            r_s_sr <= (r_s_sr >> 1) | w_fa_sum_msb;
            if (w_last) begin
                r_sum   <= {w_fa_sum, r_s_sr};
                r_carry <= w_fa_carry;
            end
        end
    end

endmodule

// File: tb/tb_module_serial_adder.sv
// Bench for module_serial_adder: an 8-bit and a 2-bit instance checked every
// cycle against a cycle-count/arithmetic model, plus directed literal cases.
module tb_module_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start [2];
    logic [7:0] opa   [2];
    logic [7:0] opb   [2];
    logic       cin   [2];

    logic       rdy8, cy8, vld8;
    logic [7:0] sum8;
    logic       rdy2, cy2, vld2;
    logic [1:0] sum2;

    int pass_cnt = 0;
    int total_cnt = 0;

    module_serial_adder #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]),
        .i_operand1(opa[0]), .i_operand2(opb[0]), .i_carry(cin[0]),
        .o_ready(rdy8), .o_sum(sum8), .o_carry(cy8), .o_valid(vld8)
    );

    module_serial_adder #(.WIDTH(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]),
        .i_operand1(opa[1][1:0]), .i_operand2(opb[1][1:0]), .i_carry(cin[1]),
        .o_ready(rdy2), .o_sum(sum2), .o_carry(cy2), .o_valid(vld2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        else pass_cnt++;
    endtask

    // Exact (w+1)-bit result of a + b + cin restricted to w-bit operands.
    function automatic logic [8:0] ref_add(input int w, input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] m;
        m = 9'((1 << w) - 1);
        return ({1'b0, a} & m) + ({1'b0, b} & m) + {8'b0, c};
    endfunction

    function automatic logic [8:0] dut_res(input int d);
        return (d == 0) ? {cy8, sum8} : {6'b0, cy2, sum2};
    endfunction

    function automatic logic dut_vld(input int d);
        return (d == 0) ? vld8 : vld2;
    endfunction

    function automatic logic dut_rdy(input int d);
        return (d == 0) ? rdy8 : rdy2;
    endfunction

    // Model: a request is taken whenever the block is free or in its result
    // cycle; the result appears WIDTH cycles after the accepting edge and is
    // held until the next one.
    int         wid [2] = '{8, 2};
    int         cyc;
    bit         pend [2];
    int         due  [2];
    logic [8:0] exp_res [2];
    logic [8:0] held    [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            for (int d = 0; d < 2; d++) begin
                pend[d] = 1'b0;
                due[d] = 0;
                held[d] = '0;
                exp_res[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit rdy;
                rdy = !pend[d] || (cyc == due[d]);
                if (pend[d] && cyc == due[d]) pend[d] = 1'b0;
                if (start[d] && rdy) begin
                    pend[d] = 1'b1;
                    due[d] = cyc + 1 + wid[d];
                    exp_res[d] = ref_add(wid[d], opa[d], opb[d], cin[d]);
                end
                if (pend[d] && (cyc + 1 == due[d])) held[d] = exp_res[d];
            end
            cyc++;
        end
    end

    // Every cycle: handshake outputs and held result against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ready[w%0d]", wid[d]), 32'(dut_rdy(d)), 32'(!pend[d] || (cyc == due[d])));
            chk($sformatf("valid[w%0d]", wid[d]), 32'(dut_vld(d)), 32'(pend[d] && (cyc == due[d])));
            chk($sformatf("result[w%0d]", wid[d]), 32'(dut_res(d)), 32'(held[d]));
        end
    end

    // Issue one request on instance d from an idle block and wait for its result.
    task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic c,
                          output int lat, output logic [8:0] res);
        @(negedge clk);
        start[d] = 1'b1; opa[d] = a; opb[d] = b; cin[d] = c;
        @(negedge clk);
        start[d] = 1'b0;
        lat = 0;
        while (!dut_vld(d) && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!dut_vld(d)) chk("valid_timeout", 32'(lat), 32'(wid[d]));
        res = dut_res(d);
    endtask

    int         lat;
    int         gap;
    int         nvalid;
    logic [8:0] res;

    initial begin
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; opa[d] = '0; opb[d] = '0; cin[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_ready", 32'(rdy8), 32'd1);
        chk("reset_valid", 32'(vld8), 32'd0);
        chk("reset_result", 32'({cy8, sum8}), 32'd0);

        // Basic sums with literal expectations and latency.
        run_op(0, 8'h5A, 8'h33, 1'b0, lat, res);
        chk("lat_5A_33", 32'(lat), 32'd8);
        chk("sum_5A_33", 32'(res), 32'h08D);
        run_op(0, 8'hFF, 8'h01, 1'b0, lat, res);
        chk("sum_FF_01", 32'(res), 32'h100);
        run_op(0, 8'hFF, 8'hFF, 1'b1, lat, res);
        chk("sum_FF_FF_1", 32'(res), 32'h1FF);

        // Back-to-back: second request taken in the first one's result cycle.
        @(negedge clk);
        start[0] = 1'b1; opa[0] = 8'h5A; opb[0] = 8'h33; cin[0] = 1'b0;
        @(negedge clk);
        opa[0] = 8'h10; opb[0] = 8'h20;
        lat = 0;
        while (!vld8 && lat < 30) begin @(negedge clk); lat++; end
        chk("b2b_first_sum", 32'({cy8, sum8}), 32'h08D);
        gap = 0;
        @(negedge clk); gap++;
        start[0] = 1'b0;
        chk("b2b_ready_low", 32'(rdy8), 32'd0);
        while (!vld8 && gap < 30) begin
            chk("b2b_hold_first", 32'({cy8, sum8}), 32'h08D);
            @(negedge clk); gap++;
        end
        chk("b2b_gap", 32'(gap), 32'd9);
        chk("b2b_second_sum", 32'({cy8, sum8}), 32'h030);

        // Request pulsed mid-add is ignored.
        @(negedge clk);
        @(negedge clk);
        start[0] = 1'b1; opa[0] = 8'hAA; opb[0] = 8'h11; cin[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin start[0] = 1'b1; opa[0] = 8'h22; opb[0] = 8'h33; end
            if (i == 4) start[0] = 1'b0;
            if (vld8) begin
                nvalid++;
                chk("ignore_sum", 32'({cy8, sum8}), 32'h0BB);
            end
            @(negedge clk);
        end
        chk("ignore_valid_count", 32'(nvalid), 32'd1);

        // Asynchronous reset in the middle of an addition.
        @(negedge clk);
        start[0] = 1'b1; opa[0] = 8'h5A; opb[0] = 8'h33; cin[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sum", 32'({cy8, sum8}), 32'd0);
        chk("async_rst_valid", 32'(vld8), 32'd0);
        chk("async_rst_ready", 32'(rdy8), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            if (vld8) nvalid++;
            @(negedge clk);
        end
        chk("abort_no_valid", 32'(nvalid), 32'd0);
        run_op(0, 8'h01, 8'h01, 1'b0, lat, res);
        chk("after_rst_sum", 32'(res), 32'h002);

        // Random requests, some arriving while busy; the model decides acceptance.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start[0] = ($urandom_range(0, 2) == 0);
            opa[0] = 8'($urandom);
            opb[0] = 8'($urandom);
            cin[0] = 1'($urandom);
        end
        @(negedge clk);
        start[0] = 1'b0;
        repeat (12) @(negedge clk);

        // WIDTH=2 exhaustive.
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++) begin
                    run_op(1, 8'(a), 8'(b), 1'(c), lat, res);
                    chk($sformatf("w2_lat_%0d_%0d_%0d", a, b, c), 32'(lat), 32'd2);
                    chk($sformatf("w2_sum_%0d_%0d_%0d", a, b, c), 32'(res), 32'(a + b + c));
                end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
